// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI constants and AR state encoding for the instruction-fetch read bridge.
package inst_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] INST_AR_ID     = 4'h0;

  typedef enum logic [0:0] {
    ArIdle,
    ArSend
  } ar_state_e;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Instruction SRAM-like slave to AXI read master bridge: single-beat in-order reads,
// up to MAX_OUTSTANDING accepted-but-unreturned requests.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AR_ID           = INST_AR_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  axi_arid,
  output logic [31:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [3:0]  axi_rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic        rd_err,
  output logic [1:0]  outstanding
);

  localparam logic [1:0] MaxOut = 2'(MAX_OUTSTANDING);

  ar_state_e   state_q;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic [1:0]  outstanding_q, outstanding_d;
  logic        data_ok_q;
  logic        rd_err_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        r_hs;
  logic [3:0]  unused_rid;

  // Responses return in order, so the R id carries no information here.
  assign unused_rid = axi_rid;

  // Gated by reset so nothing is accepted in a cycle whose state is being discarded.
  assign accept = ~reset & (state_q == ArIdle) & inst_sram_req & ~inst_sram_wr &
                  (outstanding_q < MaxOut);
  assign r_hs   = axi_rvalid & axi_rready & axi_rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ArIdle;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arsize_q  <= '0;
    end else begin
      case (state_q)
        ArIdle: begin
          if (accept) begin
            state_q   <= ArSend;
            arvalid_q <= 1'b1;
            araddr_q  <= inst_sram_addr;
            arsize_q  <= {1'b0, inst_sram_size};
          end
        end
        ArSend: begin
          if (axi_arready) begin
            state_q   <= ArIdle;
            arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ArIdle;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, r_hs})
      2'b10:   outstanding_d = outstanding_q + 2'd1;
      2'b01:   outstanding_d = outstanding_q - 2'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      data_ok_q     <= 1'b0;
      rd_err_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      data_ok_q     <= r_hs;
      rd_err_q      <= r_hs & (axi_rresp != AXI_RESP_OKAY);
      if (r_hs) begin
        rdata_q <= axi_rdata;
      end
    end
  end

  assign inst_sram_addr_ok = accept;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;
  assign axi_arid          = AR_ID;
  assign axi_araddr        = araddr_q;
  assign axi_arlen         = 8'd0;
  assign axi_arsize        = arsize_q;
  assign axi_arburst       = AXI_BURST_INCR;
  assign axi_arvalid       = arvalid_q;
  // Non-last beats are drained too; only the rlast beat completes a read.
  assign axi_rready        = (outstanding_q != 2'd0);
  assign rd_err            = rd_err_q;
  assign outstanding       = outstanding_q;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Randomized bench for inst_axi_rd_bridge: transaction-level reference model plus a
// read-data scoreboard drained by an independent monitor.
module tb_inst_axi_rd_bridge;

  localparam int Max = 2;

  logic        clk;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] r_data;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        rd_err;
  logic [1:0]  outstanding;

  inst_axi_rd_bridge #(
    .MAX_OUTSTANDING(Max),
    .AR_ID          (4'h0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_sram_req    (req),
    .inst_sram_wr     (wr),
    .inst_sram_size   (size),
    .inst_sram_addr   (addr),
    .inst_sram_addr_ok(addr_ok),
    .inst_sram_data_ok(data_ok),
    .inst_sram_rdata  (rdata),
    .axi_arid         (arid),
    .axi_araddr       (araddr),
    .axi_arlen        (arlen),
    .axi_arsize       (arsize),
    .axi_arburst      (arburst),
    .axi_arvalid      (arvalid),
    .axi_arready      (arready),
    .axi_rid          (rid),
    .axi_rdata        (r_data),
    .axi_rresp        (rresp),
    .axi_rlast        (rlast),
    .axi_rvalid       (rvalid),
    .axi_rready       (rready),
    .rd_err           (rd_err),
    .outstanding      (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: reads accepted but not returned, whether an AR is still owed to
  // the bus, the address/size it must carry, and AR-completed reads awaiting R.
  int          m_cnt = 0;
  bit          m_ar_busy = 1'b0;
  logic [31:0] m_araddr = '0;
  logic [2:0]  m_arsize = '0;
  int          m_pending = 0;
  logic [31:0] next_addr = 32'h1c00_0000;
  logic [32:0] sb[$];

  int p_req = 0, p_wr = 0, p_arready = 100, p_rvalid = 0, p_err = 0, p_spur = 0;
  int p_reset = 0;
  bit force_reset = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each data_ok must match the oldest completed R beat; otherwise data holds.
  logic [31:0] last_rdata = '0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (data_ok === 1'b1) begin
      if (sb.size() == 0) begin
        chk("data_ok_unexpected", 32'(data_ok), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", rdata, e[31:0]);
        chk("rd_err", 32'(rd_err), 32'(e[32]));
        last_rdata = e[31:0];
      end
    end else begin
      chk("rdata_hold", rdata, last_rdata);
      chk("rd_err_idle", 32'(rd_err), 32'd0);
    end
    if (reset) begin
      sb.delete();
      last_rdata = '0;
    end
  end

  task automatic cycle();
    bit exp_ok, acc, arhs, rhs;
    @(posedge clk);
    #1;
    reset   = force_reset || ($urandom_range(0, 999) < p_reset);
    req     = $urandom_range(0, 99) < p_req;
    wr      = $urandom_range(0, 99) < p_wr;
    size    = 2'($urandom_range(0, 2));
    addr    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : next_addr;
    arready = $urandom_range(0, 99) < p_arready;
    rid     = 4'($urandom);
    r_data  = 32'($urandom);
    rresp   = ($urandom_range(0, 99) < p_err) ? 2'($urandom_range(1, 3)) : 2'b00;
    rlast   = 1'b1;
    rvalid  = 1'b0;
    if (m_pending > 0 && $urandom_range(0, 99) < p_rvalid) begin
      rvalid = 1'b1;
      rlast  = ($urandom_range(0, 7) != 0);
    end else if (m_cnt == 0 && $urandom_range(0, 99) < p_spur) begin
      rvalid = 1'b1;
    end
    @(negedge clk);
    #1;
    exp_ok = !reset && req && !wr && !m_ar_busy && (m_cnt < Max);
    chk("addr_ok", 32'(addr_ok), 32'(exp_ok));
    chk("arvalid", 32'(arvalid), 32'(m_ar_busy));
    if (m_ar_busy) begin
      chk("araddr", araddr, m_araddr);
      chk("arsize", 32'(arsize), 32'(m_arsize));
    end
    chk("rready", 32'(rready), 32'(m_cnt != 0));
    chk("outstanding", 32'(outstanding), 32'(m_cnt));
    chk("ar_consts", {arid, arlen, 18'd0, arburst}, {4'h0, 8'h00, 18'd0, 2'b01});
    if (reset) begin
      m_cnt = 0;
      m_ar_busy = 1'b0;
      m_pending = 0;
    end else begin
      acc  = exp_ok;
      arhs = m_ar_busy && arready;
      rhs  = rvalid && (m_cnt != 0) && rlast;
      if (rhs) begin
        sb.push_back({rresp != 2'b00, r_data});
        m_pending--;
      end
      if (arhs) begin
        m_ar_busy = 1'b0;
        m_pending++;
      end
      if (acc) begin
        m_ar_busy = 1'b1;
        m_araddr  = addr;
        m_arsize  = {1'b0, size};
        next_addr = next_addr + 32'd4;
      end
      m_cnt = m_cnt + int'(acc) - int'(rhs);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int budget;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0;
    arready = 1'b0; rid = '0; r_data = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    force_reset = 1'b1;
    run(3);
    force_reset = 1'b0;

    // Single fetch with an eager slave.
    p_req = 100; p_arready = 100; p_rvalid = 100;
    run(1);
    p_req = 0;
    run(6);

    // Fill to the limit with R withheld, then release.
    p_req = 100; p_rvalid = 0;
    run(10);
    p_rvalid = 100;
    run(6);

    // AR stall.
    p_arready = 0; p_rvalid = 50;
    run(6);
    p_arready = 100;
    run(6);

    // Illegal writes, error responses, stray rvalid.
    p_req = 100; p_wr = 100; p_spur = 100;
    run(6);
    p_wr = 0; p_err = 100; p_rvalid = 100;
    run(10);

    // Fully random traffic with sporadic resets.
    p_req = 70; p_wr = 20; p_arready = 60; p_rvalid = 50; p_err = 15; p_spur = 30;
    p_reset = 3;
    run(3000);
    p_reset = 0;

    // Reset while an AR is owed and two reads are outstanding.
    p_req = 100; p_wr = 0; p_arready = 100; p_rvalid = 0; p_spur = 0;
    budget = 50;
    while (!(m_cnt == Max && m_ar_busy) && budget > 0) begin
      cycle();
      budget--;
    end
    chk("reach_full_send", 32'(budget > 0), 32'd1);
    p_arready = 0;
    run(2);
    force_reset = 1'b1;
    run(1);
    force_reset = 1'b0;
    p_req = 0;
    run(3);

    // Drain.
    p_req = 0; p_arready = 100; p_rvalid = 100; p_err = 0;
    run(20);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("model_idle", 32'(m_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
